bus_ram_wlog: RTL and testbench
===============================

BUS_RAM_WLOG -- requirements
Module: bus_ram_wlog

Interface
REQ-001 The module SHALL have parameter RAM_AWIDTH, default 11, RAM address width (2 KiB decoded at 0x0000..(2^RAM_AWIDTH)-1).
REQ-002 The module SHALL have parameter LOG_DEPTH, default 8, write-log FIFO entries (power of two, 2..16).
REQ-003 The module SHALL have port clk, input, 1, system clock (same clk driving cpu6502).
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port address, input, 16, CPU bus address.
REQ-006 The module SHALL have port wdata, input, 8, CPU write data (cpu odata).
REQ-007 The module SHALL have port rw, input, 1, 1 = read, 0 = write.
REQ-008 The module SHALL have port clk2, input, 1, CPU phi2 phase output.
REQ-009 The module SHALL have port rdata, output, 8, read data to CPU idata.
REQ-010 The module SHALL have port log_pop, input, 1, consume oldest log entry.
REQ-011 The module SHALL have port log_valid, output, 1, log non-empty.
REQ-012 The module SHALL have port log_data, output, 24, oldest entry {address[15:0], data[7:0]}.
REQ-013 The module SHALL have port log_count, output, 5, current entry count.
REQ-014 The module SHALL have port log_overflow, output, 1, sticky: a write was dropped.

Function
REQ-015 A write SHALL be committed only on the clk edge at which registered clk2 is 0 and clk2 is 1 (phi2 rising edge), with rw == 0.
REQ-016 A committed write with address < 2^RAM_AWIDTH SHALL store wdata at address[RAM_AWIDTH-1:0]; out-of-range writes SHALL NOT modify RAM.
REQ-017 rdata SHALL be registered: one clk after address is sampled, rdata = RAM[address] if in range, else 8'h00.
REQ-018 During a write commit cycle, rdata SHALL update to the newly written value on the next clk (write-first).
REQ-019 Holding clk2 high with rw == 0 SHALL commit exactly one write per phi2 rising edge.
REQ-020 Every committed write, in or out of range, SHALL push {address, wdata} to the log.
REQ-021 log_data/log_valid SHALL reflect the FIFO head combinationally from registered state; log_count SHALL equal entries held (0..LOG_DEPTH).
REQ-022 log_pop while log_valid == 0 SHALL be ignored.
REQ-023 A push when log_count == LOG_DEPTH and no pop SHALL drop the entry and set log_overflow.
REQ-024 A simultaneous push and pop when full SHALL perform both; count unchanged; no overflow.
REQ-025 A simultaneous push and pop when empty SHALL leave the pushed entry held, count 1.
REQ-026 Read/write pointers SHALL wrap modulo LOG_DEPTH.
REQ-027 log_overflow SHALL remain set until reset.

Reset
REQ-028 While reset == 0: rdata = 8'h00, log_count = 0, log_valid = 0, log_data = 0, log_overflow = 0, clk2 edge register = 0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-write SHALL abort the commit and the log push for that cycle.

Configuration
REQ-031 With macro BUS_RAM_WLOG_WRITE_LOG_EN defined, the write-log FIFO SHALL be built per REQ-020..REQ-027.
REQ-032 Without BUS_RAM_WLOG_WRITE_LOG_EN, no FIFO storage SHALL exist; log_valid, log_data, log_count, log_overflow SHALL be constant 0; log_pop ignored; RAM behaviour unchanged.

Verification
REQ-033 Reset release, address = 0x0000 with rw = 1 -> rdata = 0x00, log_count = 0, log_overflow = 0.
REQ-034 STA $99 (address 0x0099, wdata 0x00, rw 0, clk2 rising) -> log_data = 0x009900, log_count = 1; subsequent read of 0x0099 returns 0x00.
REQ-035 Write 0x42 to 0x07FF then read 0x07FF -> rdata = 0x42 one clk later; write 0x55 to 0x0800 -> RAM unchanged, read of 0x0800 returns 0x00, log entry 0x080055.
REQ-036 Nine writes (0x0010..0x0018, data 0x01..0x09), no pops -> log_count = 8, log_overflow = 1, head = 0x001001; eight pops -> last entry 0x001708.
REQ-037 Full log, simultaneous push 0x0020/0xAA and pop -> log_count stays 8, log_overflow stays 0, tail entry = 0x0020AA.
REQ-038 Build without BUS_RAM_WLOG_WRITE_LOG_EN, run REQ-034 stimulus -> RAM write occurs, all log outputs remain 0.

Source files
------------

// File: rtl/bus_ram_wlog.sv
// CPU-bus RAM with registered write-first read port and an optional write-log FIFO.
// Macro BUS_RAM_WLOG_WRITE_LOG_EN builds the write log; without it the log outputs are tied to 0.
module bus_ram_wlog #(
  parameter int unsigned RAM_AWIDTH = 11,
  parameter int unsigned LOG_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        clk2,
  output logic [7:0]  rdata,
  input  logic        log_pop,
  output logic        log_valid,
  output logic [23:0] log_data,
  output logic [4:0]  log_count,
  output logic        log_overflow
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AWIDTH;

  logic                  clk2_q;
  logic [7:0]            rdata_q, rdata_d;
  logic [7:0]            ram_q [RAM_WORDS];
  logic                  in_range;
  logic                  commit;
  logic [RAM_AWIDTH-1:0] ram_idx;

  // Commit gated by reset so an edge arriving while reset is held writes nothing.
  always_comb begin
    in_range = {16'h0000, address} < RAM_WORDS;
    ram_idx  = address[RAM_AWIDTH-1:0];
    commit   = reset & ~clk2_q & clk2 & ~rw;
    rdata_d  = '0;
    if (in_range) rdata_d = commit ? wdata : ram_q[ram_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk2_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      clk2_q  <= clk2;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && in_range) ram_q[ram_idx] <= wdata;
  end

  assign rdata = rdata_q;

`ifdef BUS_RAM_WLOG_WRITE_LOG_EN
  localparam int unsigned PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [23:0]   fifo_q [LOG_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop, full;

  // A pop on a full log frees the slot the same-cycle push lands in.
  always_comb begin
    do_pop  = log_pop && (count_q != '0);
    full    = (count_q == 5'(LOG_DEPTH));
    do_push = commit && (!full || do_pop);
    ovf_d   = ovf_q | (commit & full & ~do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q + {4'b0000, do_push} - {4'b0000, do_pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wptr_q] <= {address, wdata};
  end

  assign log_valid    = (count_q != '0);
  assign log_data     = log_valid ? fifo_q[rptr_q] : '0;
  assign log_count    = count_q;
  assign log_overflow = ovf_q;
`else
  logic unused_log_pop;
  assign unused_log_pop = log_pop;
  assign log_valid      = 1'b0;
  assign log_data       = '0;
  assign log_count      = '0;
  assign log_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ram_wlog.sv
// Bench for bus_ram_wlog: vector table, directed log corner cases and random traffic vs a queue model.
module tb_bus_ram_wlog;

`ifdef BUS_RAM_WLOG_WRITE_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk, rst_n;
  logic [15:0] address;
  logic [7:0]  wdata, rdata;
  logic        rw, clk2, log_pop;
  logic        log_valid, log_overflow;
  logic [23:0] log_data;
  logic [4:0]  log_count;

  bus_ram_wlog dut (
    .clk(clk), .reset(rst_n), .address(address), .wdata(wdata), .rw(rw),
    .clk2(clk2), .rdata(rdata), .log_pop(log_pop), .log_valid(log_valid),
    .log_data(log_data), .log_count(log_count), .log_overflow(log_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: byte array with known-flags, plus a queue for the log.
  logic [7:0]  m_ram   [2048];
  bit          m_known [2048];
  logic [23:0] m_q[$];
  bit          m_ovf, m_prev_c2, m_rd_known;
  logic [7:0]  m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf      = 1'b0;
    m_prev_c2  = 1'b0;
    m_rd       = 8'h00;
    m_rd_known = 1'b1;
  endtask

  task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input bit r, input bit c2, input bit p);
    bit commit, inr, pop_ok, full;
    commit = !m_prev_c2 && c2 && !r;
    inr    = a < 16'd2048;
    if (commit && inr) begin
      m_ram[a[10:0]]   = d;
      m_known[a[10:0]] = 1'b1;
    end
    m_rd       = inr ? m_ram[a[10:0]] : 8'h00;
    m_rd_known = inr ? m_known[a[10:0]] : 1'b1;
    m_prev_c2  = c2;
    pop_ok = p && (m_q.size() != 0);
    full   = (m_q.size() == DEPTH);
    if (pop_ok) void'(m_q.pop_front());
    if (commit) begin
      if (!full || pop_ok) m_q.push_back({a, d});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    if (m_rd_known) chk("rdata", {24'h0, rdata}, {24'h0, m_rd});
    chk("log_valid", {31'h0, log_valid}, {31'h0, LOG_EN && m_q.size() != 0});
    chk("log_data", {8'h0, log_data}, (LOG_EN && m_q.size() != 0) ? {8'h0, m_q[0]} : 32'h0);
    chk("log_count", {27'h0, log_count}, LOG_EN ? m_q.size() : 0);
    chk("log_overflow", {31'h0, log_overflow}, {31'h0, LOG_EN && m_ovf});
  endtask

  task automatic step(input logic [15:0] a, input logic [7:0] d, input bit r, input bit c2, input bit p);
    address = a; wdata = d; rw = r; clk2 = c2; log_pop = p;
    @(posedge clk);
    model_edge(a, d, r, c2, p);
    #1;
    check_outputs();
  endtask

  // Reset is asserted with the current inputs left in place, so a pending commit is aborted.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs();
      clk2 = ~clk2;
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          r, c2, p;
    logic [7:0]  rd;
    logic [4:0]  cnt;
    logic [23:0] head;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{16'h0099, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 24'h009900};
    tbl[1]  = '{16'h0099, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 24'h009900};
    tbl[2]  = '{16'h07FF, 8'h42, 1'b0, 1'b1, 1'b0, 8'h42, 5'd2, 24'h009900};
    tbl[3]  = '{16'h07FF, 8'h00, 1'b1, 1'b1, 1'b0, 8'h42, 5'd2, 24'h009900};
    tbl[4]  = '{16'h07FF, 8'h13, 1'b0, 1'b1, 1'b0, 8'h42, 5'd2, 24'h009900};
    tbl[5]  = '{16'h0800, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 24'h009900};
    tbl[6]  = '{16'h0800, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 5'd3, 24'h009900};
    tbl[7]  = '{16'h0800, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd3, 24'h009900};
    tbl[8]  = '{16'h07FF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd2, 24'h07FF42};
    tbl[9]  = '{16'h07FF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd1, 24'h080055};
    tbl[10] = '{16'h07FF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd0, 24'h000000};
    tbl[11] = '{16'h07FF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd0, 24'h000000};

    for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
    address = 16'h0000; wdata = 8'h00; rw = 1'b1; clk2 = 1'b0; log_pop = 1'b0;
    do_reset();
    step(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].c2, tbl[i].p);
      chk("tbl_rdata", {24'h0, rdata}, {24'h0, tbl[i].rd});
      chk("tbl_count", {27'h0, log_count}, LOG_EN ? {27'h0, tbl[i].cnt} : 32'h0);
      chk("tbl_head", {8'h0, log_data}, LOG_EN ? {8'h0, tbl[i].head} : 32'h0);
    end

    // Nine writes into an eight-entry log.
    for (int k = 0; k < 9; k++) begin
      step(16'h0010 + 16'(k), 8'(k + 1), 1'b0, 1'b0, 1'b0);
      step(16'h0010 + 16'(k), 8'(k + 1), 1'b0, 1'b1, 1'b0);
    end
    chk("ovf_count", {27'h0, log_count}, LOG_EN ? 32'd8 : 32'd0);
    chk("ovf_flag", {31'h0, log_overflow}, {31'h0, LOG_EN});
    chk("ovf_head", {8'h0, log_data}, LOG_EN ? 32'h001001 : 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("last_entry", {8'h0, log_data}, LOG_EN ? 32'h001708 : 32'h0);
      step(16'h0010, 8'h00, 1'b1, 1'b0, 1'b1);
    end
    chk("ovf_sticky", {31'h0, log_overflow}, {31'h0, LOG_EN});

    // Reset landing on a pending write must not commit it.
    step(16'h0123, 8'h11, 1'b0, 1'b0, 1'b0);
    step(16'h0123, 8'h11, 1'b0, 1'b1, 1'b0);
    step(16'h0123, 8'hEE, 1'b0, 1'b0, 1'b0);
    clk2 = 1'b1;
    do_reset();
    step(16'h0123, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("abort_rdata", {24'h0, rdata}, 32'h11);
    step(16'h0099, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("ram_kept", {24'h0, rdata}, 32'h00);

    // Full log with simultaneous push and pop.
    for (int k = 0; k < 8; k++) begin
      step(16'h0030 + 16'(k), 8'(k), 1'b0, 1'b0, 1'b0);
      step(16'h0030 + 16'(k), 8'(k), 1'b0, 1'b1, 1'b0);
    end
    step(16'h0020, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(16'h0020, 8'hAA, 1'b0, 1'b1, 1'b1);
    chk("full_pp_count", {27'h0, log_count}, LOG_EN ? 32'd8 : 32'd0);
    chk("full_pp_ovf", {31'h0, log_overflow}, 32'h0);
    for (int k = 0; k < 7; k++) step(16'h0020, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("tail_entry", {8'h0, log_data}, LOG_EN ? 32'h0020AA : 32'h0);
    step(16'h0020, 8'h00, 1'b1, 1'b0, 1'b1);

    // Empty log with simultaneous push and pop keeps the pushed entry.
    step(16'h0021, 8'hBB, 1'b0, 1'b0, 1'b0);
    step(16'h0021, 8'hBB, 1'b0, 1'b1, 1'b1);
    chk("empty_pp_count", {27'h0, log_count}, LOG_EN ? 32'd1 : 32'd0);
    chk("empty_pp_head", {8'h0, log_data}, LOG_EN ? 32'h0021BB : 32'h0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(16'($urandom_range(16'h07E0, 16'h081F)), 8'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
